// File: rtl/frame_store_pkg.sv
// Shared definitions for the frame store: read FSM states and descriptor layout.
// A descriptor is {start, len}: start is the RAM address of byte 0 (ADDR_W bits),
// len is the frame length in bytes (ADDR_W+1 bits so a completely full RAM fits).
package frame_store_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } rd_state_e;

   // len occupies the low bits of a descriptor word, start sits directly above it.
   localparam int DESC_LEN_LSB = 0;

   function automatic int desc_len_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic int desc_start_lsb(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic int desc_w(input int addr_w);
      return 2 * addr_w + 1;
   endfunction

endpackage

// File: rtl/frame_store_fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with 1-cycle latency.
// Ports: clk_i/rst_i, write (wr_en_i, wr_addr_i, wr_data_i), read (rd_en_i, rd_addr_i, rd_data_o).
// The read register only updates when rd_en_i is high, so the last word read is held.
module sdp_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;

   // Storage array has no reset so it maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register is reset so the consumer sees zero after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q <= '0;
      end else if (rd_en_i) begin
         rd_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/frame_store_fifo.sv
// Packet buffer behind frame_receiver: stores frame bytes in a circular RAM, commits
// frames with good CRC (rewinds otherwise) and streams committed frames out with
// sop/eop/len over valid/ready. Ports: ick/i_rst; input byte stream idv/irx_d with
// i_error/i_crc; output o_dv/o_data/o_sop/o_eop/o_len with i_ready; status o_pkt_cnt,
// o_free, o_drop_cnt.
module frame_store_fifo
   import frame_store_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 11,
   parameter int DESC_AW = 4,
   parameter int DROP_W  = 16
) (
   input  logic               ick,
   input  logic               i_rst,
   input  logic               idv,
   input  logic [DATA_W-1:0]  irx_d,
   input  logic               i_error,
   input  logic               i_crc,
   input  logic               i_ready,
   output logic               o_dv,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_sop,
   output logic               o_eop,
   output logic [ADDR_W:0]    o_len,
   output logic [DESC_AW:0]   o_pkt_cnt,
   output logic [ADDR_W:0]    o_free,
   output logic [DROP_W-1:0]  o_drop_cnt
);

   localparam int PW        = ADDR_W + 1;
   localparam int LEN_W     = desc_len_w(ADDR_W);
   localparam int START_LSB = desc_start_lsb(ADDR_W);
   localparam int DW_DESC   = desc_w(ADDR_W);

   localparam logic [PW-1:0]    RAM_FULL_LVL  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [DESC_AW:0] DESC_FULL_LVL = {1'b1, {DESC_AW{1'b0}}};
   localparam logic [PW-1:0]    ONE_P         = {{ADDR_W{1'b0}}, 1'b1};

   // ------------------------------------------------------------------
   // Write side state
   // ------------------------------------------------------------------
   logic [PW-1:0]      wr_tmp_q, wr_tmp_d;
   logic [PW-1:0]      wr_commit_q, wr_commit_d;
   logic               prev_dv_q;
   logic               in_frame_q;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d;
   logic [DESC_AW:0]   desc_wp_q, desc_wp_d;
   logic [DESC_AW:0]   pkt_cnt_q, pkt_cnt_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

   // ------------------------------------------------------------------
   // Read side state
   // ------------------------------------------------------------------
   rd_state_e          state_q;
   logic [PW-1:0]      rd_ptr_q;
   logic [DESC_AW:0]   desc_rp_q;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [PW-1:0]      len_q;
   logic [PW-1:0]      rem_q;
   logic               dv_q;
   logic               sop_q;
   logic               eop_q;

   // ------------------------------------------------------------------
   // Frame delimiting
   // ------------------------------------------------------------------
   logic frm_start, frm_active, frm_end;
   logic [PW-1:0] held_bytes, frm_len;
   logic ram_full, ram_wr, desc_full, desc_empty;
   logic commit, drop;
   logic xfer, last_xfer;

   // prev_dv_q resets high: a frame already in progress at reset release is
   // ignored until idv has been seen low.
   assign frm_start  = idv & ~prev_dv_q;
   assign frm_active = idv & (in_frame_q | frm_start);
   assign frm_end    = ~idv & in_frame_q;

   // Space is measured against rd_ptr, so bytes of a frame still being read stay protected.
   assign held_bytes = wr_tmp_q - rd_ptr_q;
   assign ram_full   = (held_bytes == RAM_FULL_LVL);
   assign ram_wr     = frm_active & ~ram_full;
   assign frm_len    = wr_tmp_q - wr_commit_q;

   assign desc_full  = ((desc_wp_q - desc_rp_q) == DESC_FULL_LVL);
   assign desc_empty = (desc_wp_q == desc_rp_q);

   // Error flagged on the end cycle itself also taints the frame.
   assign commit = frm_end & i_crc & ~(err_q | i_error) & ~ovf_q
                 & (frm_len != '0) & ~desc_full;
   assign drop   = frm_end & ~commit;

   assign xfer      = dv_q & i_ready;
   assign last_xfer = xfer & eop_q;

   always_comb begin
      wr_tmp_d    = wr_tmp_q;
      wr_commit_d = wr_commit_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      desc_wp_d   = desc_wp_q;
      pkt_cnt_d   = pkt_cnt_q;
      drop_cnt_d  = drop_cnt_q;

      if (frm_start) begin
         err_d = i_error;
         ovf_d = ram_full;
      end else if (frm_active) begin
         err_d = err_q | i_error;
         ovf_d = ovf_q | ram_full;
      end

      if (ram_wr) begin
         wr_tmp_d = wr_tmp_q + 1'b1;
      end

      if (commit) begin
         wr_commit_d = wr_tmp_q;
         desc_wp_d   = desc_wp_q + 1'b1;
      end else if (drop) begin
         // Rewind so the rejected frame's bytes are simply overwritten later.
         wr_tmp_d = wr_commit_q;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end

      // Commit and end-of-read in the same cycle cancel out.
      if (commit && !last_xfer) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else if (!commit && last_xfer) begin
         pkt_cnt_d = pkt_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge ick or posedge i_rst) begin
      if (i_rst) begin
         wr_tmp_q    <= '0;
         wr_commit_q <= '0;
         prev_dv_q   <= 1'b1;
         in_frame_q  <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         desc_wp_q   <= '0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         wr_tmp_q    <= wr_tmp_d;
         wr_commit_q <= wr_commit_d;
         prev_dv_q   <= idv;
         in_frame_q  <= frm_active;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
         desc_wp_q   <= desc_wp_d;
         pkt_cnt_q   <= pkt_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Descriptor FIFO storage
   // ------------------------------------------------------------------
   logic [DW_DESC-1:0] desc_wr_dat, desc_rd_dat;
   logic [ADDR_W-1:0]  d_start;
   logic [PW-1:0]      d_len;

   always_comb begin
      desc_wr_dat = '0;
      desc_wr_dat[START_LSB +: ADDR_W]  = wr_commit_q[ADDR_W-1:0];
      desc_wr_dat[DESC_LEN_LSB +: LEN_W] = frm_len;
   end

   assign d_start = desc_rd_dat[START_LSB +: ADDR_W];
   assign d_len   = desc_rd_dat[DESC_LEN_LSB +: LEN_W];

   // Read address tracks desc_rp_q every cycle, so the head descriptor is on the
   // RAM output by the time the FSM reaches LOAD.
   sdp_ram #(
      .DATA_W (DW_DESC),
      .ADDR_W (DESC_AW)
   ) u_desc_ram (
      .clk_i     (ick),
      .rst_i     (i_rst),
      .wr_en_i   (commit),
      .wr_addr_i (desc_wp_q[DESC_AW-1:0]),
      .wr_data_i (desc_wr_dat),
      .rd_en_i   (1'b1),
      .rd_addr_i (desc_rp_q[DESC_AW-1:0]),
      .rd_data_o (desc_rd_dat)
   );

   // ------------------------------------------------------------------
   // Data RAM
   // ------------------------------------------------------------------
   logic              dram_rd_en;
   logic [ADDR_W-1:0] dram_rd_addr;

   // The registered read output doubles as the one-entry skid: a new byte is only
   // fetched when the current one transfers, so a stall simply holds it, and a
   // continuously ready sink still gets one byte per cycle.
   assign dram_rd_en   = (state_q == LOAD) | (xfer & ~eop_q);
   assign dram_rd_addr = (state_q == LOAD) ? d_start : rd_addr_q;

   sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_data_ram (
      .clk_i     (ick),
      .rst_i     (i_rst),
      .wr_en_i   (ram_wr),
      .wr_addr_i (wr_tmp_q[ADDR_W-1:0]),
      .wr_data_i (irx_d),
      .rd_en_i   (dram_rd_en),
      .rd_addr_i (dram_rd_addr),
      .rd_data_o (o_data)
   );

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   always_ff @(posedge ick or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         rd_ptr_q  <= '0;
         desc_rp_q <= '0;
         rd_addr_q <= '0;
         len_q     <= '0;
         rem_q     <= '0;
         dv_q      <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!desc_empty) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               desc_rp_q <= desc_rp_q + 1'b1;
               len_q     <= d_len;
               rem_q     <= d_len - 1'b1;
               rd_addr_q <= d_start + 1'b1;
               dv_q      <= 1'b1;
               sop_q     <= 1'b1;
               eop_q     <= (d_len == ONE_P);
               state_q   <= STREAM;
            end
            STREAM: begin
               if (xfer) begin
                  sop_q <= 1'b0;
                  if (eop_q) begin
                     dv_q     <= 1'b0;
                     eop_q    <= 1'b0;
                     rd_ptr_q <= rd_ptr_q + len_q;
                     state_q  <= IDLE;
                  end else begin
                     rem_q     <= rem_q - 1'b1;
                     eop_q     <= (rem_q == ONE_P);
                     rd_addr_q <= rd_addr_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_dv       = dv_q;
   assign o_sop      = sop_q;
   assign o_eop      = eop_q;
   assign o_len      = len_q;
   assign o_pkt_cnt  = pkt_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
   assign o_free     = RAM_FULL_LVL - (wr_commit_q - rd_ptr_q);

endmodule

// File: tb/tb_frame_store_fifo.sv
module tb_frame_store_fifo;

   logic        ick;
   logic        i_rst;
   logic        idv;
   logic [7:0]  irx_d;
   logic        i_error;
   logic        i_crc;
   logic        i_ready;

   // default-size instance (2048 bytes)
   logic        a_dv, a_sop, a_eop;
   logic [7:0]  a_data;
   logic [11:0] a_len, a_free;
   logic [4:0]  a_pkt;
   logic [15:0] a_drop;

   // small instance (64 bytes)
   logic        b_dv, b_sop, b_eop;
   logic [7:0]  b_data;
   logic [6:0]  b_len, b_free;
   logic [4:0]  b_pkt;
   logic [15:0] b_drop;

   int n_chk;
   int n_fail;
   int q_a[$];
   int q_b[$];
   bit bp_on;
   int hold_err;
   int n_stall;

   frame_store_fifo dut_a (
      .ick        (ick),
      .i_rst      (i_rst),
      .idv        (idv),
      .irx_d      (irx_d),
      .i_error    (i_error),
      .i_crc      (i_crc),
      .i_ready    (i_ready),
      .o_dv       (a_dv),
      .o_data     (a_data),
      .o_sop      (a_sop),
      .o_eop      (a_eop),
      .o_len      (a_len),
      .o_pkt_cnt  (a_pkt),
      .o_free     (a_free),
      .o_drop_cnt (a_drop)
   );

   frame_store_fifo #(.ADDR_W(6)) dut_b (
      .ick        (ick),
      .i_rst      (i_rst),
      .idv        (idv),
      .irx_d      (irx_d),
      .i_error    (i_error),
      .i_crc      (i_crc),
      .i_ready    (i_ready),
      .o_dv       (b_dv),
      .o_data     (b_data),
      .o_sop      (b_sop),
      .o_eop      (b_eop),
      .o_len      (b_len),
      .o_pkt_cnt  (b_pkt),
      .o_free     (b_free),
      .o_drop_cnt (b_drop)
   );

   initial ick = 1'b0;
   always #5 ick = ~ick;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int exp_beat(input bit sop, input bit eop, input int len, input int data);
      return (int'(sop) << 21) | (int'(eop) << 20) | ((len & 12'hFFF) << 8) | (data & 255);
   endfunction

   // Transfers are decided by signals that are stable at the falling edge.
   logic [10:0] prev_a;
   bit          stall_a;
   always @(negedge ick) begin
      if (a_dv && i_ready) q_a.push_back({10'd0, a_sop, a_eop, a_len, a_data});
      if (b_dv && i_ready) q_b.push_back({10'd0, b_sop, b_eop, 5'd0, b_len, b_data});
      if (stall_a && ({a_dv, a_sop, a_eop, a_data} != prev_a)) hold_err++;
      stall_a = a_dv && !i_ready;
      if (stall_a) n_stall++;
      prev_a  = {a_dv, a_sop, a_eop, a_data};
   end

   // Ready pattern 1,0,0,1 repeating while enabled.
   initial begin
      int idx = 0;
      forever begin
         @(posedge ick); #1;
         if (bp_on) begin
            i_ready = (idx == 0) || (idx == 3);
            idx = (idx + 1) % 4;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge ick); #1;
   endtask

   task automatic do_reset();
      step();
      i_rst = 1'b1; idv = 1'b0; i_error = 1'b0; i_crc = 1'b0;
      step();
      i_rst = 1'b0;
      q_a.delete(); q_b.delete();
      step();
   endtask

   // Returns in the cycle right after the frame-end cycle.
   task automatic send_frame(input int n, input int base, input bit crc, input int err_at);
      for (int i = 0; i < n; i++) begin
         idv = 1'b1;
         irx_d = 8'((base + i) & 255);
         i_error = (i == err_at);
         step();
      end
      idv = 1'b0; i_error = 1'b0; i_crc = crc;
      step();
      i_crc = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((a_pkt != 0 || b_pkt != 0 || a_dv || b_dv) && n < 3000) begin
         step();
         n++;
      end
      check("drain_in_budget", int'(n < 3000), 1);
   endtask

   task automatic chk_frame(input string tag, input int q[$], input int n, input int base);
      check({tag, "_beats"}, q.size(), n);
      for (int i = 0; i < n && i < q.size(); i++)
         check(tag, q[i], exp_beat(i == 0, i == n - 1, n, base + i));
   endtask

   initial begin
      int n;
      n_chk = 0; n_fail = 0; bp_on = 0; hold_err = 0; n_stall = 0;
      i_rst = 1'b1; idv = 1'b0; irx_d = '0; i_error = 1'b0; i_crc = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge ick);
      @(negedge ick);
      check("rst_dv",   a_dv, 0);
      check("rst_data", a_data, 0);
      check("rst_sop",  a_sop, 0);
      check("rst_eop",  a_eop, 0);
      check("rst_len",  a_len, 0);
      check("rst_pkt",  a_pkt, 0);
      check("rst_free", a_free, 2048);
      check("rst_drop", a_drop, 0);
      check("rst_free_small", b_free, 64);
      step();
      i_rst = 1'b0;
      step();

      // good 64-byte frame, latency and content
      send_frame(64, 0, 1, -1);
      @(negedge ick);
      check("t1_pkt_commit", a_pkt, 1);
      check("t1_free_held", a_free, 1984);
      check("t1_dv_c1", a_dv, 0);
      @(negedge ick);
      check("t1_dv_c2", a_dv, 0);
      @(negedge ick);
      check("t1_dv_sop_c3", {a_dv, a_sop}, 3);
      check("t1_len", a_len, 64);
      step();
      wait_drain();
      chk_frame("t1_frame", q_a, 64, 0);
      check("t1_pkt_end", a_pkt, 0);
      check("t1_free_end", a_free, 2048);

      // bad CRC frame then a good one
      do_reset();
      send_frame(64, 0, 0, -1);
      @(negedge ick);
      check("t2_drop", a_drop, 1);
      check("t2_pkt", a_pkt, 0);
      check("t2_free", a_free, 2048);
      step();
      send_frame(32, 'h80, 1, -1);
      wait_drain();
      chk_frame("t2_frame", q_a, 32, 'h80);
      check("t2_drop_end", a_drop, 1);

      // error pulse inside a good-CRC frame
      do_reset();
      send_frame(100, 0, 1, 10);
      @(negedge ick);
      check("t3_drop", a_drop, 1);
      check("t3_pkt", a_pkt, 0);
      step();
      wait_drain();
      check("t3_no_dv", q_a.size(), 0);
      check("t3_free", a_free, 2048);

      // backpressure
      do_reset();
      hold_err = 0; n_stall = 0;
      bp_on = 1;
      send_frame(20, 'h40, 1, -1);
      wait_drain();
      bp_on = 0;
      i_ready = 1'b1;
      chk_frame("t4_frame", q_a, 20, 'h40);
      check("t4_hold", hold_err, 0);
      check("t4_stalls_seen", int'(n_stall > 0), 1);

      // small RAM: overflow, then wrap-around
      do_reset();
      send_frame(80, 0, 1, -1);
      @(negedge ick);
      check("t5_ovf_drop", b_drop, 1);
      check("t5_ovf_pkt", b_pkt, 0);
      check("t5_big_kept", a_pkt, 1);
      step();
      wait_drain();
      check("t5_ovf_no_out", q_b.size(), 0);
      q_b.delete();
      send_frame(40, 'h10, 1, -1);
      wait_drain();
      chk_frame("t5_first", q_b, 40, 'h10);
      for (int k = 0; k < 3; k++) begin
         q_b.delete();
         send_frame(40, 'h50 + k * 'h30, 1, -1);
         @(negedge ick);
         check("t5_free_held", b_free, 24);
         step();
         wait_drain();
         chk_frame("t5_wrap", q_b, 40, 'h50 + k * 'h30);
         check("t5_free_end", b_free, 64);
      end
      check("t5_drop_end", b_drop, 1);

      // reset mid-frame, with idv still high across reset release
      do_reset();
      for (int i = 0; i < 30; i++) begin
         idv = 1'b1; irx_d = 8'(i); step();
      end
      i_rst = 1'b1;
      @(negedge ick);
      check("t6a_dv", a_dv, 0);
      check("t6a_pkt", a_pkt, 0);
      check("t6a_free", a_free, 2048);
      check("t6a_drop", a_drop, 0);
      step();
      i_rst = 1'b0;
      repeat (5) step();
      idv = 1'b0;
      repeat (4) step();
      check("t6a_ignored_pkt", a_pkt, 0);
      check("t6a_ignored_drop", a_drop, 0);
      check("t6a_ignored_free", a_free, 2048);

      // reset mid-output
      send_frame(64, 0, 1, -1);
      n = 0;
      while (q_a.size() < 5 && n < 200) begin
         @(negedge ick);
         n++;
      end
      check("t6b_beat5_reached", int'(q_a.size() >= 5), 1);
      step();
      i_rst = 1'b1;
      @(negedge ick);
      check("t6b_dv", a_dv, 0);
      check("t6b_data", a_data, 0);
      check("t6b_sop_eop", {a_sop, a_eop}, 0);
      check("t6b_len", a_len, 0);
      check("t6b_pkt", a_pkt, 0);
      check("t6b_free", a_free, 2048);
      check("t6b_drop", a_drop, 0);
      step();
      i_rst = 1'b0;
      q_a.delete(); q_b.delete();
      step();
      send_frame(16, 'hA0, 1, -1);
      wait_drain();
      chk_frame("t6c_frame", q_a, 16, 'hA0);
      check("t6c_drop", a_drop, 0);
      check("t6c_free", a_free, 2048);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
